// File: rtl/pcie_pkt_sf_buf.sv
// Store-and-forward packet buffer for the pcie_clk side of a PIO/DMA channel.
// Optional packet dropping on tdisc: define PCIEI_SF_DROP_EN.
module pcie_pkt_sf_buf #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned KEEP_W = DATA_W / 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned STAT_W = 16
) (
  input  logic              pcie_clk,
  input  logic              pcie_rst_n,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [KEEP_W-1:0] s_axis_tkeep,
  input  logic              s_axis_tdisc,
  output logic              s_axis_tready,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tdisc,
  input  logic              m_axis_tready,
  output logic [ADDR_W:0]   fill_lvl,
  output logic [ADDR_W:0]   pkt_cnt,
  output logic              force_active,
  output logic [STAT_W-1:0] force_cnt,
  output logic [STAT_W-1:0] drop_cnt
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned ENT_W = DATA_W + KEEP_W + 2;
  localparam logic [ADDR_W:0] FULL_LVL = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic {ST_STORE, ST_FORCE} state_t;

  state_t            state;
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W:0]   pkt_q;
  logic [STAT_W-1:0] force_q;
  logic [ENT_W-1:0]  mem [DEPTH];
  logic [ENT_W-1:0]  head;
  logic              full;
  logic              empty;
  logic              wr_en;
  logic              rd_en;
  logic              head_last;
  logic              enter_force;
  logic              drop;
  logic              pkt_inc;
  logic              pkt_dec;
  logic [ADDR_W:0]   rewind_ptr;

  assign fill_lvl      = wr_ptr - rd_ptr;
  assign full          = (fill_lvl == FULL_LVL);
  assign empty         = (fill_lvl == '0);
  assign pkt_cnt       = pkt_q;
  assign force_active  = (state == ST_FORCE);
  assign force_cnt     = force_q;
  assign enter_force   = (state == ST_STORE) && full && (pkt_q == '0);

  // Ready depends only on registered pointers, never on m_axis_tready.
  assign s_axis_tready = !full;
  assign m_axis_tvalid = !empty && ((pkt_q != '0) || force_active);

  assign wr_en     = s_axis_tvalid && s_axis_tready;
  assign rd_en     = m_axis_tvalid && m_axis_tready;
  assign head      = mem[rd_ptr[ADDR_W-1:0]];
  assign head_last = head[DATA_W+KEEP_W];

  always_comb begin
    {m_axis_tdisc, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = '0;
    if (m_axis_tvalid) begin
      {m_axis_tdisc, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = head;
    end
  end

  always_ff @(posedge pcie_clk) begin
    if (wr_en) begin
      mem[wr_ptr[ADDR_W-1:0]] <= {s_axis_tdisc & s_axis_tlast, s_axis_tlast,
                                  s_axis_tkeep, s_axis_tdata};
    end
  end

`ifdef PCIEI_SF_DROP_EN
  logic              in_pkt;
  logic              wr_forced;
  logic [ADDR_W:0]   start_ptr;
  logic [STAT_W-1:0] drop_q;

  // The packet being written when FORCE is entered is already streaming out
  // and can no longer be rewound; it is marked until its tlast is written.
  assign drop       = wr_en && s_axis_tlast && s_axis_tdisc && !wr_forced;
  assign rewind_ptr = in_pkt ? start_ptr : wr_ptr;
  assign drop_cnt   = drop_q;

  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      in_pkt    <= 1'b0;
      wr_forced <= 1'b0;
      start_ptr <= '0;
      drop_q    <= '0;
    end else begin
      if (enter_force) begin
        wr_forced <= 1'b1;
      end
      if (wr_en) begin
        if (!in_pkt) begin
          start_ptr <= wr_ptr;
        end
        in_pkt <= !s_axis_tlast;
        if (s_axis_tlast) begin
          wr_forced <= 1'b0;
        end
      end
      if (drop && (drop_q != '1)) begin
        drop_q <= drop_q + 1'b1;
      end
    end
  end
`else
  assign drop       = 1'b0;
  assign rewind_ptr = wr_ptr;
  assign drop_cnt   = '0;
`endif

  assign pkt_inc = wr_en && s_axis_tlast && !drop;
  assign pkt_dec = rd_en && head_last;

  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      pkt_q  <= '0;
    end else begin
      if (drop) begin
        wr_ptr <= rewind_ptr;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (pkt_inc && !pkt_dec) begin
        pkt_q <= pkt_q + 1'b1;
      end else if (pkt_dec && !pkt_inc) begin
        pkt_q <= pkt_q - 1'b1;
      end
    end
  end

  // A full buffer holding no complete packet would deadlock; stream it out.
  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      state   <= ST_STORE;
      force_q <= '0;
    end else begin
      case (state)
        ST_STORE: begin
          if (enter_force) begin
            state <= ST_FORCE;
            if (force_q != '1) begin
              force_q <= force_q + 1'b1;
            end
          end
        end
        ST_FORCE: begin
          if (rd_en && head_last) begin
            state <= ST_STORE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_pkt_sf_buf.sv
// Bench for pcie_pkt_sf_buf: queue-based reference model checked every cycle,
// plus directed literal expectations. Honours PCIEI_SF_DROP_EN when defined.
module tb_pcie_pkt_sf_buf;

  localparam int DATA_W = 256;
  localparam int KEEP_W = 8;
  localparam int ADDR_W = 5;
  localparam int STAT_W = 16;
  localparam int DEPTH  = 32;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic              disc;
  } beat_t;

  logic              pcie_clk;
  logic              pcie_rst_n;
  logic              s_axis_tvalid;
  logic              s_axis_tlast;
  logic [DATA_W-1:0] s_axis_tdata;
  logic [KEEP_W-1:0] s_axis_tkeep;
  logic              s_axis_tdisc;
  logic              s_axis_tready;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic [DATA_W-1:0] m_axis_tdata;
  logic [KEEP_W-1:0] m_axis_tkeep;
  logic              m_axis_tdisc;
  logic              m_axis_tready;
  logic [ADDR_W:0]   fill_lvl;
  logic [ADDR_W:0]   pkt_cnt;
  logic              force_active;
  logic [STAT_W-1:0] force_cnt;
  logic [STAT_W-1:0] drop_cnt;

  pcie_pkt_sf_buf #(
    .DATA_W(DATA_W),
    .KEEP_W(KEEP_W),
    .ADDR_W(ADDR_W),
    .STAT_W(STAT_W)
  ) dut (
    .pcie_clk     (pcie_clk),
    .pcie_rst_n   (pcie_rst_n),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tdisc (s_axis_tdisc),
    .s_axis_tready(s_axis_tready),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tdisc (m_axis_tdisc),
    .m_axis_tready(m_axis_tready),
    .fill_lvl     (fill_lvl),
    .pkt_cnt      (pkt_cnt),
    .force_active (force_active),
    .force_cnt    (force_cnt),
    .drop_cnt     (drop_cnt)
  );

  initial pcie_clk = 1'b0;
  always #5 pcie_clk = ~pcie_clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int failures = 0;

  // Reference model: buffer contents as a queue of beats.
  beat_t       mq[$];
  bit          m_force;
  int          m_fcnt;
  int          m_dcnt;
  bit          last_wr;
`ifdef PCIEI_SF_DROP_EN
  bit          m_wr_forced;
  int          m_cur;
`endif

  // Stimulus source and controls.
  beat_t       src[$];
  bit          src_en = 1'b1;
  int          s_rate = 100;
  int          m_mode = 1;   // 0: stall, 1: always ready, 2: random
  int unsigned seq = 1;

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int m_pkts();
    int n = 0;
    foreach (mq[i]) if (mq[i].last) n++;
    return n;
  endfunction

  function automatic bit m_valid();
    return (mq.size() != 0) && ((m_pkts() != 0) || m_force);
  endfunction

  function automatic logic [DATA_W-1:0] data_of(input int unsigned s);
    logic [DATA_W-1:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = s * 32'h9E3779B1 + 32'(i);
    return d;
  endfunction

  task automatic add_beat(input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k,
                          input bit last, input bit disc);
    beat_t b;
    b.data = d; b.keep = k; b.last = last; b.disc = disc;
    src.push_back(b);
  endtask

  task automatic add_pkt(input int len, input bit disc);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.data = data_of(seq);
      seq++;
      b.last = (i == len - 1);
      b.keep = b.last ? 8'($urandom_range(255, 1)) : 8'hFF;
      b.disc = b.last ? disc : 1'($urandom_range(1));
      src.push_back(b);
    end
  endtask

  task automatic model_step();
    bit rd, wr, enter;
    if (!pcie_rst_n) begin
      mq.delete();
      m_force = 0; m_fcnt = 0; m_dcnt = 0; last_wr = 0;
`ifdef PCIEI_SF_DROP_EN
      m_wr_forced = 0; m_cur = 0;
`endif
      return;
    end
    rd    = m_valid() && m_axis_tready;
    wr    = s_axis_tvalid && (mq.size() != DEPTH);
    enter = !m_force && (mq.size() == DEPTH) && (m_pkts() == 0);
    if (rd) begin
      if (mq[0].last && m_force) m_force = 0;
      void'(mq.pop_front());
    end
    if (enter) begin
      m_force = 1;
      if (m_fcnt < 65535) m_fcnt++;
`ifdef PCIEI_SF_DROP_EN
      m_wr_forced = 1;
`endif
    end
    if (wr) begin
      beat_t b;
      b.data = s_axis_tdata; b.keep = s_axis_tkeep;
      b.last = s_axis_tlast; b.disc = s_axis_tdisc && s_axis_tlast;
      mq.push_back(b);
`ifdef PCIEI_SF_DROP_EN
      m_cur++;
      if (s_axis_tlast) begin
        if (s_axis_tdisc && !m_wr_forced) begin
          repeat (m_cur) void'(mq.pop_back());
          if (m_dcnt < 65535) m_dcnt++;
        end
        m_cur = 0;
        m_wr_forced = 0;
      end
`endif
    end
    last_wr = wr;
  endtask

  task automatic reset_checks();
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tready", s_axis_tready, 1);
    chk("rst_fill", fill_lvl, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_force", force_active, 0);
    chk("rst_force_cnt", force_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdisc", m_axis_tdisc, 0);
  endtask

  task automatic compare_model();
    bit v;
    v = m_valid();
    chk("tvalid", m_axis_tvalid, v);
    chk("tready", s_axis_tready, mq.size() != DEPTH);
    chk("fill_lvl", fill_lvl, mq.size());
    chk("fill_max", fill_lvl <= DEPTH, 1);
    chk("pkt_cnt", pkt_cnt, m_pkts());
    chk("force_active", force_active, m_force);
    chk("force_cnt", force_cnt, m_fcnt);
    chk("drop_cnt", drop_cnt, m_dcnt);
    chk("tdata", m_axis_tdata, v ? mq[0].data : '0);
    chk("tkeep", m_axis_tkeep, v ? mq[0].keep : '0);
    chk("tlast", m_axis_tlast, v ? mq[0].last : 1'b0);
    chk("tdisc", m_axis_tdisc, v ? mq[0].disc : 1'b0);
  endtask

  task automatic cycle();
    @(negedge pcie_clk);
    if (!pcie_rst_n) reset_checks();
    else compare_model();
    @(posedge pcie_clk);
    model_step();
    #1;
  endtask

  task automatic step();
    s_axis_tvalid = src_en && (src.size() != 0) && ($urandom_range(99) < s_rate);
    if (s_axis_tvalid) begin
      s_axis_tdata = src[0].data; s_axis_tkeep = src[0].keep;
      s_axis_tlast = src[0].last; s_axis_tdisc = src[0].disc;
    end else begin
      s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 0; s_axis_tdisc = 0;
    end
    m_axis_tready = (m_mode == 2) ? ($urandom_range(99) < 60) : (m_mode == 1);
    cycle();
    if (last_wr) void'(src.pop_front());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while ((src.size() != 0 || mq.size() != 0) && k < budget) begin
      step();
      k++;
    end
    chk({name, "_fill"}, fill_lvl, 0);
    chk({name, "_tvalid"}, m_axis_tvalid, 0);
  endtask

  initial begin
    pcie_rst_n = 0;
    s_axis_tvalid = 0; s_axis_tlast = 0; s_axis_tdata = '0;
    s_axis_tkeep = '0; s_axis_tdisc = 0; m_axis_tready = 0;
    #1;
    run(2);
    pcie_rst_n = 1;
    run(1);

    // Single 3-beat packet, output always ready.
    m_mode = 1;
    add_beat(256'h1111, 8'hFF, 0, 0);
    add_beat(256'h2222, 8'hFF, 0, 0);
    add_beat(256'h3333, 8'h0F, 1, 0);
    run(1);
    chk("t1_fill1", fill_lvl, 1);
    chk("t1_nvalid", m_axis_tvalid, 0);
    run(2);
    chk("t1_valid", m_axis_tvalid, 1);
    chk("t1_pkt1", pkt_cnt, 1);
    chk("t1_fill3", fill_lvl, 3);
    chk("t1_head", m_axis_tdata, 256'h1111);
    run(1);
    chk("t1_beat2", m_axis_tdata, 256'h2222);
    run(1);
    chk("t1_beat3", m_axis_tdata, 256'h3333);
    chk("t1_keep3", m_axis_tkeep, 8'h0F);
    chk("t1_last3", m_axis_tlast, 1);
    run(1);
    chk("t1_pkt0", pkt_cnt, 0);
    chk("t1_empty", m_axis_tvalid, 0);

    // Eight 4-beat packets fill the buffer, then release.
    m_mode = 0;
    for (int i = 0; i < 8; i++) add_pkt(4, 0);
    run(32);
    chk("t2_tready", s_axis_tready, 0);
    chk("t2_fill", fill_lvl, 32);
    chk("t2_pkt", pkt_cnt, 8);
    chk("t2_noforce", force_active, 0);
    m_mode = 1;
    run(32);
    chk("t2_drained", fill_lvl, 0);
    chk("t2_pkt0", pkt_cnt, 0);

    // 40-beat packet forces FORCE mode.
    m_mode = 0;
    add_pkt(40, 0);
    run(32);
    chk("t3_full", fill_lvl, 32);
    chk("t3_store", force_active, 0);
    run(1);
    chk("t3_force", force_active, 1);
    chk("t3_force_cnt", force_cnt, 1);
    chk("t3_valid", m_axis_tvalid, 1);
    m_mode = 1;
    drain("t3", 200);
    chk("t3_exit", force_active, 0);
    chk("t3_force_cnt_end", force_cnt, 1);

    // Discontinued 5-beat packet between two good packets.
    m_mode = 0;
    add_pkt(3, 0);
    run(3);
    chk("t4_pre", fill_lvl, 3);
    add_pkt(5, 1);
    run(5);
`ifdef PCIEI_SF_DROP_EN
    chk("t4_fill", fill_lvl, 3);
    chk("t4_pkt", pkt_cnt, 1);
    chk("t4_drop", drop_cnt, 1);
`else
    chk("t4_fill", fill_lvl, 8);
    chk("t4_pkt", pkt_cnt, 2);
    chk("t4_drop", drop_cnt, 0);
`endif
    add_pkt(2, 0);
    m_mode = 1;
    drain("t4", 100);

    // Random traffic: 1000 packets of 1..16 beats.
    m_mode = 2;
    s_rate = 70;
    for (int i = 0; i < 1000; i++) add_pkt($urandom_range(16, 1), $urandom_range(9) == 0);
    drain("t5", 60000);
    s_rate = 100;

    // Reset with a partial packet stored and one beat already read.
    m_mode = 0;
    add_pkt(2, 0);
    add_pkt(4, 0);
    run(4);
    chk("t6_fill4", fill_lvl, 4);
    src_en = 0;
    m_mode = 1;
    run(1);
    chk("t6_fill3", fill_lvl, 3);
    pcie_rst_n = 0;
    #1;
    chk("t6_rst_fill", fill_lvl, 0);
    chk("t6_rst_valid", m_axis_tvalid, 0);
    chk("t6_rst_ready", s_axis_tready, 1);
    chk("t6_rst_data", m_axis_tdata, 0);
    src.delete();
    run(1);
    pcie_rst_n = 1;
    src_en = 1;
    add_pkt(3, 0);
    drain("t6", 100);
    chk("t6_pkt0", pkt_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
